pipelined_control: RTL and testbench
====================================

Name: pipelined_control

Overview:
- Pipelined successor to the single-cycle control decoder.
- Decodes one instruction per cycle and registers the control bundle into the ID/EX pipeline register.
- Detects load-use hazards and inserts one bubble for each.
- Provides valid/ready handshakes to fetch and to execute, and flushes on taken branch or jump.
- Sits between the fetch stage and the ALU/execute stage.

Parameters:
- REG_ADDR_W, 5, register-file address width (Rs, Rt, Rd, WriteRegister).
- IMM_W, 16, immediate field width; must be 16 for this ISA encoding.
- TARGET_W, 26, jump target field width.
- ENABLE_ADDI, 1, when 1 decode ADDI (opcode 001000); when 0 ADDI is illegal.
- HAZARD_EN, 1, when 0 load-use detection is disabled and no bubbles are inserted.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- InstrValid  in  1  fetch presents Instr this cycle.
- Instr  in  32  instruction word.
- InstrReady  out  1  combinational; instruction accepted when InstrValid && InstrReady at the edge.
- Flush  in  1  discard the held output and all hazard state (taken branch or jump resolved downstream).
- ExReady  in  1  execute stage accepts the output bundle this cycle.
- OutValid  out  1  the registered bundle below is valid.
- RegWr, MemWr, MemToReg, ALUSrc, Branch, Jump, JR, ZeroExt  out  1 each  registered control bits.
- ALUCntrl  out  2  00 add, 01 xor, 10 sub, 11 slt.
- Rs, Rt, WriteRegister  out  REG_ADDR_W  registered register addresses.
- Imm16  out  IMM_W  registered immediate.
- TargetInstr  out  TARGET_W  registered jump target.
- Illegal  out  1  registered; the instruction is undecodable.

Behaviour:
- Reset:
  - All outputs 0, including OutValid and Illegal.
  - FSM goes to RUN; the load-pending flag is cleared.
  - InstrReady is 0 while reset is high.
- Decode: all don't-care fields are driven 0, never x.
  - ADD (funct 100000) and SUB (100010): RegDst=Rd, RegWr=1, ALUCntrl 00 / 10.
  - SLT (101010): RegDst=Rd, RegWr=1, ALUCntrl 11.
  - JR (funct 001000): Jump=1, JR=1, RegWr=0.
  - LW (100011): ALUSrc=1, MemToReg=1, RegWr=1, WriteRegister=Rt, ALUCntrl 00.
  - SW (101011): ALUSrc=1, MemWr=1, ALUCntrl 00.
  - BNE (000101): Branch=1, ALUCntrl 10.
  - XORI (001110): ALUSrc=1, ZeroExt=1, RegWr=1, WriteRegister=Rt, ALUCntrl 01.
  - ADDI (001000): like LW but MemToReg=0.
  - J (000010): Jump=1, JR=0.
  - Anything else: Illegal=1, all write enables 0, OutValid still 1.
- Register 0: RegWr is forced 0 whenever WriteRegister==0.
- Latency: one cycle from accept to OutValid.
- Backpressure:
  - While OutValid && !ExReady, all outputs hold and InstrReady=0.
  - Otherwise InstrReady=1, except in the load-use case below.
- Load-use hazard, tracked with LdPend (1 bit) and LdReg (REG_ADDR_W bits):
  - An accepted LW with Rt!=0 sets LdPend=1 and LdReg=Rt. Any other accepted instruction or bubble clears LdPend.
  - If LdPend, InstrValid, HAZARD_EN, and the new instruction sources LdReg, then:
    - InstrReady=0 this cycle.
    - FSM goes RUN->BUBBLE.
    - Next cycle OutValid=0 with fields zeroed, and LdPend clears.
    - BUBBLE->RUN unconditionally; the held instruction is then accepted.
  - Source rules: Rs is a source for all types except J. Rt is a source for R-type (except JR), SW and BNE.
- Flush:
  - Highest priority after reset.
  - Next cycle: OutValid=0, LdPend=0, FSM=RUN, regardless of ExReady or state.
  - An instruction presented in the same cycle as Flush is not accepted (InstrReady=0).
- Simultaneous events:
  - Flush overrides both hazard and backpressure.
  - The hazard check uses LdPend before that edge's update.
- Mid-operation reset: identical to reset from power-up.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - Opcode and funct localparams.
  - ALUCntrl encodings.
  - The packed struct ctrl_bundle_t (the control bits, ALUCntrl and Illegal).
- Sub-module ctrl_decode is purely combinational: Instr -> ctrl_bundle_t plus the UsesRs/UsesRt flags.
- pipelined_control owns the FSM, the hazard state and the output register.

Test Plan:
- Reset, then ADD $3,$1,$2 (0x00221820) with ExReady=1 -> next cycle OutValid=1, RegWr=1, WriteRegister=3, ALUCntrl=00, Illegal=0.
- LW $5,4($1) (0x8C250004), then ADD $6,$5,$2 (0x00A23020) -> InstrReady=0 for one cycle, one OutValid=0 bubble, then ADD issues with WriteRegister=6.
- Same sequence with HAZARD_EN=0 -> no bubble; back-to-back OutValid=1.
- ADD 0x00220020 (rd=0) -> RegWr=0, OutValid=1.
- Opcode 0xFC000000 -> Illegal=1, RegWr=0, MemWr=0.
- J 0x08000010 held with ExReady=0 for 3 cycles, then Flush=1 -> outputs stable for 3 cycles (TargetInstr=0x0000010), then OutValid=0.
- Flush asserted during a BUBBLE cycle -> LdPend cleared, FSM=RUN, and the instruction presented in the Flush cycle is not accepted.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the pipelined control decoder:
//   - opcode / funct encodings of the supported instruction subset
//   - ALUCntrl encodings
//   - ctrl_bundle_t : the registered control bits handed to execute
//   - state_t       : RUN / BUBBLE issue state
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // ALUCntrl encodings
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_XOR  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_SLT  = 2'b11;

    // Issue state: BUBBLE lasts exactly one cycle after a load-use stall
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    // Control bits carried into the ID/EX register
    typedef struct packed {
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jr;
        logic       zero_ext;
        logic [1:0] alu_cntrl;
        logic       illegal;
    } ctrl_bundle_t;

    // All-inactive bundle, used for bubbles, flushes and reset
    localparam ctrl_bundle_t CTRL_NONE = '{
        reg_wr:     1'b0,
        mem_wr:     1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        branch:     1'b0,
        jump:       1'b0,
        jr:         1'b0,
        zero_ext:   1'b0,
        alu_cntrl:  2'b00,
        illegal:    1'b0
    };

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational instruction decoder.
// Ports:
//   instr_i    [31:0]        instruction word
//   ctrl_o     ctrl_bundle_t decoded control bits (RegWr already masked for $0)
//   uses_rs_o                instruction reads Rs
//   uses_rt_o                instruction reads Rt
//   is_load_o                instruction is LW
//   rs_o, rt_o, wr_reg_o     register fields; unused ones are driven 0
//   imm_o      [IMM_W-1:0]   immediate (I-type only, else 0)
//   target_o   [TARGET_W-1:0] jump target (J only, else 0)
// ---------------------------------------------------------------------------
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int IMM_W       = 16,
    parameter int TARGET_W    = 26,
    parameter int ENABLE_ADDI = 1
) (
    input  logic [31:0]           instr_i,
    output ctrl_bundle_t          ctrl_o,
    output logic                  uses_rs_o,
    output logic                  uses_rt_o,
    output logic                  is_load_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [REG_ADDR_W-1:0] wr_reg_o,
    output logic [IMM_W-1:0]      imm_o,
    output logic [TARGET_W-1:0]   target_o
);

    logic [5:0]            opcode_s;
    logic [5:0]            funct_s;
    logic [REG_ADDR_W-1:0] rs_f_s;
    logic [REG_ADDR_W-1:0] rt_f_s;
    logic [REG_ADDR_W-1:0] rd_f_s;

    ctrl_bundle_t base_s;
    logic         uses_rs_s;
    logic         uses_rt_s;
    logic         writes_rd_s;
    logic         writes_rt_s;
    logic         imm_en_s;
    logic         tgt_en_s;
    logic         load_s;

    assign opcode_s = instr_i[31:26];
    assign funct_s  = instr_i[5:0];
    assign rs_f_s   = instr_i[21 +: REG_ADDR_W];
    assign rt_f_s   = instr_i[16 +: REG_ADDR_W];
    assign rd_f_s   = instr_i[11 +: REG_ADDR_W];

    // Classify the instruction and raise its control bits and field usage
    always_comb begin
        base_s      = CTRL_NONE;
        uses_rs_s   = 1'b0;
        uses_rt_s   = 1'b0;
        writes_rd_s = 1'b0;
        writes_rt_s = 1'b0;
        imm_en_s    = 1'b0;
        tgt_en_s    = 1'b0;
        load_s      = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD, FN_SUB, FN_SLT: begin
                        base_s.reg_wr = 1'b1;
                        uses_rs_s     = 1'b1;
                        uses_rt_s     = 1'b1;
                        writes_rd_s   = 1'b1;
                        if (funct_s == FN_SUB) begin
                            base_s.alu_cntrl = ALU_SUB;
                        end else if (funct_s == FN_SLT) begin
                            base_s.alu_cntrl = ALU_SLT;
                        end else begin
                            base_s.alu_cntrl = ALU_ADD;
                        end
                    end
                    FN_JR: begin
                        base_s.jump = 1'b1;
                        base_s.jr   = 1'b1;
                        uses_rs_s   = 1'b1;
                    end
                    default: begin
                        base_s.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                base_s.alu_src    = 1'b1;
                base_s.mem_to_reg = 1'b1;
                base_s.reg_wr     = 1'b1;
                base_s.alu_cntrl  = ALU_ADD;
                uses_rs_s         = 1'b1;
                writes_rt_s       = 1'b1;
                imm_en_s          = 1'b1;
                load_s            = 1'b1;
            end
            OP_SW: begin
                base_s.alu_src   = 1'b1;
                base_s.mem_wr    = 1'b1;
                base_s.alu_cntrl = ALU_ADD;
                uses_rs_s        = 1'b1;
                uses_rt_s        = 1'b1;
                imm_en_s         = 1'b1;
            end
            OP_BNE: begin
                base_s.branch    = 1'b1;
                base_s.alu_cntrl = ALU_SUB;
                uses_rs_s        = 1'b1;
                uses_rt_s        = 1'b1;
                imm_en_s         = 1'b1;
            end
            OP_XORI: begin
                base_s.alu_src   = 1'b1;
                base_s.zero_ext  = 1'b1;
                base_s.reg_wr    = 1'b1;
                base_s.alu_cntrl = ALU_XOR;
                uses_rs_s        = 1'b1;
                writes_rt_s      = 1'b1;
                imm_en_s         = 1'b1;
            end
            OP_ADDI: begin
                if (ENABLE_ADDI != 0) begin
                    base_s.alu_src   = 1'b1;
                    base_s.reg_wr    = 1'b1;
                    base_s.alu_cntrl = ALU_ADD;
                    uses_rs_s        = 1'b1;
                    writes_rt_s      = 1'b1;
                    imm_en_s         = 1'b1;
                end else begin
                    base_s.illegal = 1'b1;
                end
            end
            OP_J: begin
                base_s.jump = 1'b1;
                tgt_en_s    = 1'b1;
            end
            default: begin
                base_s.illegal = 1'b1;
            end
        endcase
    end

    // Steer register/immediate/target fields (unused ones read 0) and mask writes to $0
    always_comb begin
        ctrl_o    = base_s;
        uses_rs_o = uses_rs_s;
        uses_rt_o = uses_rt_s;
        is_load_o = load_s;
        if (writes_rd_s) begin
            wr_reg_o = rd_f_s;
        end else if (writes_rt_s) begin
            wr_reg_o = rt_f_s;
        end else begin
            wr_reg_o = '0;
        end
        if (wr_reg_o == '0) begin
            ctrl_o.reg_wr = 1'b0;
        end else begin
            ctrl_o.reg_wr = base_s.reg_wr;
        end
        rs_o     = uses_rs_s ? rs_f_s : '0;
        rt_o     = (uses_rt_s || writes_rt_s) ? rt_f_s : '0;
        imm_o    = imm_en_s ? instr_i[0 +: IMM_W] : '0;
        target_o = tgt_en_s ? instr_i[0 +: TARGET_W] : '0;
    end

endmodule

// File: rtl/pipelined_control.sv
// ---------------------------------------------------------------------------
// pipelined_control
// Decode stage with ID/EX output register, load-use bubble insertion,
// valid/ready handshakes on both sides, and flush on redirect.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   InstrValid/Instr      instruction offered by fetch
//   InstrReady            combinational accept (valid && ready at the edge)
//   Flush                 drop the held bundle and hazard state
//   ExReady               execute takes the bundle this cycle
//   OutValid              registered bundle below is valid
//   RegWr..ZeroExt        registered control bits
//   ALUCntrl              00 add, 01 xor, 10 sub, 11 slt
//   Rs, Rt, WriteRegister registered register addresses
//   Imm16, TargetInstr    registered immediate and jump target
//   Illegal               registered undecodable flag
// ---------------------------------------------------------------------------
module pipelined_control
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int IMM_W       = 16,
    parameter int TARGET_W    = 26,
    parameter int ENABLE_ADDI = 1,
    parameter int HAZARD_EN   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  InstrValid,
    input  logic [31:0]           Instr,
    output logic                  InstrReady,
    input  logic                  Flush,
    input  logic                  ExReady,
    output logic                  OutValid,
    output logic                  RegWr,
    output logic                  MemWr,
    output logic                  MemToReg,
    output logic                  ALUSrc,
    output logic                  Branch,
    output logic                  Jump,
    output logic                  JR,
    output logic                  ZeroExt,
    output logic [1:0]            ALUCntrl,
    output logic [REG_ADDR_W-1:0] Rs,
    output logic [REG_ADDR_W-1:0] Rt,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [IMM_W-1:0]      Imm16,
    output logic [TARGET_W-1:0]   TargetInstr,
    output logic                  Illegal
);

    // Decoder outputs
    ctrl_bundle_t          dec_ctrl_s;
    logic                  dec_uses_rs_s;
    logic                  dec_uses_rt_s;
    logic                  dec_is_load_s;
    logic [REG_ADDR_W-1:0] dec_rs_s;
    logic [REG_ADDR_W-1:0] dec_rt_s;
    logic [REG_ADDR_W-1:0] dec_wr_s;
    logic [IMM_W-1:0]      dec_imm_s;
    logic [TARGET_W-1:0]   dec_tgt_s;

    // Registered state
    state_t                state_q;
    logic                  out_valid_q;
    ctrl_bundle_t          ctrl_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [REG_ADDR_W-1:0] wr_q;
    logic [IMM_W-1:0]      imm_q;
    logic [TARGET_W-1:0]   tgt_q;
    logic                  ld_pend_q;
    logic [REG_ADDR_W-1:0] ld_reg_q;

    // Handshake terms
    logic stall_s;
    logic hazard_s;
    logic ready_s;
    logic accept_s;

    ctrl_decode #(
        .REG_ADDR_W  (REG_ADDR_W),
        .IMM_W       (IMM_W),
        .TARGET_W    (TARGET_W),
        .ENABLE_ADDI (ENABLE_ADDI)
    ) u_decode (
        .instr_i   (Instr),
        .ctrl_o    (dec_ctrl_s),
        .uses_rs_o (dec_uses_rs_s),
        .uses_rt_o (dec_uses_rt_s),
        .is_load_o (dec_is_load_s),
        .rs_o      (dec_rs_s),
        .rt_o      (dec_rt_s),
        .wr_reg_o  (dec_wr_s),
        .imm_o     (dec_imm_s),
        .target_o  (dec_tgt_s)
    );

    // Held bundle not yet taken by execute
    assign stall_s = out_valid_q && !ExReady;

    // Load-use: the offered instruction reads the register the previous LW writes.
    // LdPend is always clear in BUBBLE; the state term just makes that explicit.
    always_comb begin
        if ((HAZARD_EN != 0) && (state_q == ST_RUN) && ld_pend_q && InstrValid) begin
            hazard_s = (dec_uses_rs_s && (dec_rs_s == ld_reg_q)) ||
                       (dec_uses_rt_s && (dec_rt_s == ld_reg_q));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign ready_s    = !reset && !Flush && !stall_s && !hazard_s;
    assign accept_s   = InstrValid && ready_s;
    assign InstrReady = ready_s;

    // ID/EX register, load-pending tracker and RUN/BUBBLE state.
    // Reset and Flush both return to an empty RUN stage; backpressure freezes
    // everything; otherwise the register takes the accepted instruction or a
    // zeroed, invalid bundle (bubble or idle fetch).
    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_NONE;
            rs_q        <= '0;
            rt_q        <= '0;
            wr_q        <= '0;
            imm_q       <= '0;
            tgt_q       <= '0;
            ld_pend_q   <= 1'b0;
            ld_reg_q    <= '0;
        end else if (stall_s) begin
            state_q     <= state_q;
            out_valid_q <= out_valid_q;
            ctrl_q      <= ctrl_q;
            rs_q        <= rs_q;
            rt_q        <= rt_q;
            wr_q        <= wr_q;
            imm_q       <= imm_q;
            tgt_q       <= tgt_q;
            ld_pend_q   <= ld_pend_q;
            ld_reg_q    <= ld_reg_q;
        end else if (accept_s) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b1;
            ctrl_q      <= dec_ctrl_s;
            rs_q        <= dec_rs_s;
            rt_q        <= dec_rt_s;
            wr_q        <= dec_wr_s;
            imm_q       <= dec_imm_s;
            tgt_q       <= dec_tgt_s;
            // A load into $0 can never be consumed, so it does not arm the tracker
            ld_pend_q   <= dec_is_load_s && (dec_rt_s != '0);
            ld_reg_q    <= dec_rt_s;
        end else begin
            // Bubble or idle: an idle cycle keeps LdPend, a bubble consumes it
            state_q     <= hazard_s ? ST_BUBBLE : ST_RUN;
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_NONE;
            rs_q        <= '0;
            rt_q        <= '0;
            wr_q        <= '0;
            imm_q       <= '0;
            tgt_q       <= '0;
            ld_pend_q   <= hazard_s ? 1'b0 : ld_pend_q;
            ld_reg_q    <= ld_reg_q;
        end
    end

    assign OutValid      = out_valid_q;
    assign RegWr         = ctrl_q.reg_wr;
    assign MemWr         = ctrl_q.mem_wr;
    assign MemToReg      = ctrl_q.mem_to_reg;
    assign ALUSrc        = ctrl_q.alu_src;
    assign Branch        = ctrl_q.branch;
    assign Jump          = ctrl_q.jump;
    assign JR            = ctrl_q.jr;
    assign ZeroExt       = ctrl_q.zero_ext;
    assign ALUCntrl      = ctrl_q.alu_cntrl;
    assign Illegal       = ctrl_q.illegal;
    assign Rs            = rs_q;
    assign Rt            = rt_q;
    assign WriteRegister = wr_q;
    assign Imm16         = imm_q;
    assign TargetInstr   = tgt_q;

endmodule

// File: tb/tb_pipelined_control.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control
// Two instances (hazard detection on / off) share one stimulus stream.
// A per-cycle reference model (instruction-class equations plus LdPend/LdReg
// tracking) predicts InstrReady and the full output bundle of each instance;
// directed sequences add literal expectations from hand decoding.
// ---------------------------------------------------------------------------
module tb_pipelined_control;

    typedef struct packed {
        logic       v;
        logic       regwr;
        logic       memwr;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic       jr;
        logic       zeroext;
        logic [1:0] alu;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wr;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic       ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        InstrValid = 1'b0;
    logic [31:0] Instr = 32'd0;
    logic        Flush = 1'b0;
    logic        ExReady = 1'b1;

    wire  [68:0] vec_h;
    wire  [68:0] vec_n;
    wire         rdy_h;
    wire         rdy_n;
    exp_t        oh;
    exp_t        on;
    assign oh = vec_h;
    assign on = vec_n;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    exp_t        m_out [2];
    logic        m_ld  [2];
    logic [4:0]  m_reg [2];

    always #5 clk = ~clk;

    pipelined_control #(.HAZARD_EN(1)) dut_h (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .Instr(Instr),
        .InstrReady(rdy_h), .Flush(Flush), .ExReady(ExReady),
        .OutValid(vec_h[68]), .RegWr(vec_h[67]), .MemWr(vec_h[66]),
        .MemToReg(vec_h[65]), .ALUSrc(vec_h[64]), .Branch(vec_h[63]),
        .Jump(vec_h[62]), .JR(vec_h[61]), .ZeroExt(vec_h[60]),
        .ALUCntrl(vec_h[59:58]), .Rs(vec_h[57:53]), .Rt(vec_h[52:48]),
        .WriteRegister(vec_h[47:43]), .Imm16(vec_h[42:27]),
        .TargetInstr(vec_h[26:1]), .Illegal(vec_h[0])
    );

    pipelined_control #(.HAZARD_EN(0)) dut_n (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .Instr(Instr),
        .InstrReady(rdy_n), .Flush(Flush), .ExReady(ExReady),
        .OutValid(vec_n[68]), .RegWr(vec_n[67]), .MemWr(vec_n[66]),
        .MemToReg(vec_n[65]), .ALUSrc(vec_n[64]), .Branch(vec_n[63]),
        .Jump(vec_n[62]), .JR(vec_n[61]), .ZeroExt(vec_n[60]),
        .ALUCntrl(vec_n[59:58]), .Rs(vec_n[57:53]), .Rt(vec_n[52:48]),
        .WriteRegister(vec_n[47:43]), .Imm16(vec_n[42:27]),
        .TargetInstr(vec_n[26:1]), .Illegal(vec_n[0])
    );

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-class rules
    function automatic exp_t ref_decode(input logic [31:0] w, output bit urs, output bit urt);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        bit add, sub, slt, jr, lw, sw, bne, xori, addi, j, wrd, wrt;
        e  = '0;
        op = w[31:26];
        fn = w[5:0];
        add  = (op == 6'h00) && (fn == 6'h20);
        sub  = (op == 6'h00) && (fn == 6'h22);
        slt  = (op == 6'h00) && (fn == 6'h2a);
        jr   = (op == 6'h00) && (fn == 6'h08);
        lw   = (op == 6'h23);
        sw   = (op == 6'h2b);
        bne  = (op == 6'h05);
        xori = (op == 6'h0e);
        addi = (op == 6'h08);
        j    = (op == 6'h02);
        e.v = 1'b1;
        urs = 1'b0;
        urt = 1'b0;
        if (!(add | sub | slt | jr | lw | sw | bne | xori | addi | j)) begin
            e.ill = 1'b1;
            return e;
        end
        wrd = add | sub | slt;
        wrt = lw | xori | addi;
        e.wr       = wrd ? w[15:11] : (wrt ? w[20:16] : 5'd0);
        e.regwr    = (wrd | wrt) && (e.wr != 5'd0);
        e.memwr    = sw;
        e.memtoreg = lw;
        e.alusrc   = lw | sw | xori | addi;
        e.branch   = bne;
        e.jump     = jr | j;
        e.jr       = jr;
        e.zeroext  = xori;
        e.alu      = (sub | bne) ? 2'b10 : (slt ? 2'b11 : (xori ? 2'b01 : 2'b00));
        urs        = !j;
        urt        = wrd | sw | bne;
        e.rs       = urs ? w[25:21] : 5'd0;
        e.rt       = (urt | wrt) ? w[20:16] : 5'd0;
        e.imm      = (lw | sw | bne | xori | addi) ? w[15:0] : 16'd0;
        e.tgt      = j ? w[25:0] : 26'd0;
        return e;
    endfunction

    // Per-cycle comparison and model advance, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                exp_t d;
                bit   urs, urt, hz, stall, exp_rdy;
                d = ref_decode(Instr, urs, urt);
                hz = (k == 0) && m_ld[k] && InstrValid &&
                     ((urs && (Instr[25:21] == m_reg[k])) || (urt && (Instr[20:16] == m_reg[k])));
                stall   = m_out[k].v && !ExReady;
                exp_rdy = !reset && !Flush && !stall && !hz;
                chk(k == 0 ? "ready_h" : "ready_n", {68'd0, (k == 0) ? rdy_h : rdy_n}, {68'd0, exp_rdy});
                chk(k == 0 ? "bundle_h" : "bundle_n", (k == 0) ? vec_h : vec_n, m_out[k]);
                if (reset || Flush) begin
                    m_out[k] = '0;
                    m_ld[k]  = 1'b0;
                end else if (!stall) begin
                    if (InstrValid && exp_rdy) begin
                        m_out[k] = d;
                        m_ld[k]  = (Instr[31:26] == 6'h23) && (Instr[20:16] != 5'd0);
                        m_reg[k] = Instr[20:16];
                    end else begin
                        m_out[k] = '0;
                        if (hz) m_ld[k] = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        logic [15:0] imm;
        int unsigned sel;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        imm = 16'($urandom);
        sel = $urandom_range(0, 11);
        case (sel)
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2:  return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
            3:  return {6'h00, rs, 15'd0, 6'h08};
            4:  return {6'h23, rs, rt, imm};
            5:  return {6'h2b, rs, rt, imm};
            6:  return {6'h05, rs, rt, imm};
            7:  return {6'h0e, rs, rt, imm};
            8:  return {6'h08, rs, rt, imm};
            9:  return {6'h02, 26'($urandom)};
            10: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic exr, input logic fl);
        InstrValid = v;
        Instr      = ins;
        ExReady    = exr;
        Flush      = fl;
    endtask

    localparam logic [31:0] I_ADD3 = 32'h00221820;
    localparam logic [31:0] I_LW5  = 32'h8C250004;
    localparam logic [31:0] I_ADD6 = 32'h00A23020;
    localparam logic [31:0] I_ADD0 = 32'h00220020;
    localparam logic [31:0] I_BAD  = 32'hFC000000;
    localparam logic [31:0] I_J    = 32'h08000010;

    initial begin
        exp_t pin;
        bit   u1, u2;
        logic acc;
        for (int k = 0; k < 2; k++) begin
            m_out[k] = '0;
            m_ld[k]  = 1'b0;
            m_reg[k] = 5'd0;
        end

        // Pin the reference decoder with hand-decoded words
        pin = ref_decode(I_LW5, u1, u2);
        chk("model_lw", {pin.wr, pin.rs, pin.imm, pin.memtoreg, pin.regwr, u1, u2},
            {5'd5, 5'd1, 16'h0004, 1'b1, 1'b1, 1'b1, 1'b0});
        pin = ref_decode(I_ADD6, u1, u2);
        chk("model_add", {pin.wr, pin.rs, pin.rt, pin.alu, u1, u2},
            {5'd6, 5'd5, 5'd2, 2'b00, 1'b1, 1'b1});
        pin = ref_decode(I_J, u1, u2);
        chk("model_j", {pin.tgt, pin.jump, pin.jr, u1}, {26'h10, 1'b1, 1'b0, 1'b0});

        // Reset
        step();
        step();
        cmp_en = 1'b1;
        chk("reset_ready", {68'd0, rdy_h}, 69'd0);
        chk("reset_bundle", vec_h, 69'd0);
        reset = 1'b0;

        // ADD $3,$1,$2
        drive(1'b1, I_ADD3, 1'b1, 1'b0);
        #1 chk("add_ready", {68'd0, rdy_h}, 69'd1);
        step();
        chk("add_out", {oh.v, oh.regwr, oh.wr, oh.alu, oh.ill}, {1'b1, 1'b1, 5'd3, 2'b00, 1'b0});

        // Load-use: LW $5 then ADD $6,$5,$2
        drive(1'b1, I_LW5, 1'b1, 1'b0);
        step();
        drive(1'b1, I_ADD6, 1'b1, 1'b0);
        #1 chk("lu_stall", {rdy_h, rdy_n}, {1'b0, 1'b1});
        step();
        chk("lu_bubble", {oh.v, oh.wr}, {1'b0, 5'd0});
        chk("nohz_issue", {on.v, on.wr}, {1'b1, 5'd6});
        #1 chk("lu_release", {68'd0, rdy_h}, 69'd1);
        step();
        chk("lu_issue", {oh.v, oh.wr, oh.regwr}, {1'b1, 5'd6, 1'b1});

        // rd = $0 masks RegWr
        drive(1'b1, I_ADD0, 1'b1, 1'b0);
        step();
        chk("rd0", {oh.v, oh.regwr}, {1'b1, 1'b0});

        // Undecodable opcode
        drive(1'b1, I_BAD, 1'b1, 1'b0);
        step();
        chk("illegal", {oh.v, oh.ill, oh.regwr, oh.memwr}, {1'b1, 1'b1, 1'b0, 1'b0});

        // J held under backpressure, then flushed
        drive(1'b1, I_J, 1'b1, 1'b0);
        step();
        drive(1'b1, I_ADD3, 1'b0, 1'b0);
        #1 chk("bp_ready", {68'd0, rdy_h}, 69'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_hold", {oh.v, oh.jump, oh.tgt}, {1'b1, 1'b1, 26'h0000010});
        end
        drive(1'b1, I_ADD3, 1'b0, 1'b1);
        #1 chk("flush_ready", {68'd0, rdy_h}, 69'd0);
        step();
        chk("flush_out", {68'd0, oh.v}, 69'd0);

        // Flush during the BUBBLE cycle
        drive(1'b1, I_LW5, 1'b1, 1'b0);
        step();
        drive(1'b1, I_ADD6, 1'b1, 1'b0);
        step();
        chk("bub_state", {68'd0, oh.v}, 69'd0);
        drive(1'b1, I_ADD6, 1'b1, 1'b1);
        #1 chk("bub_flush_rdy", {68'd0, rdy_h}, 69'd0);
        step();
        chk("bub_flush_out", {68'd0, oh.v}, 69'd0);
        drive(1'b1, I_ADD6, 1'b1, 1'b0);
        #1 chk("bub_after_rdy", {68'd0, rdy_h}, 69'd1);
        step();
        chk("bub_after_out", {oh.v, oh.wr}, {1'b1, 5'd6});

        // Flush in the hazard cycle clears LdPend
        drive(1'b1, I_LW5, 1'b1, 1'b0);
        step();
        drive(1'b1, I_ADD6, 1'b1, 1'b1);
        #1 chk("hz_flush_rdy", {68'd0, rdy_h}, 69'd0);
        step();
        drive(1'b1, I_ADD6, 1'b1, 1'b0);
        #1 chk("hz_cleared_rdy", {68'd0, rdy_h}, 69'd1);
        step();

        // Randomized traffic against the model
        acc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            reset   = ($urandom_range(0, 299) == 0);
            Flush   = ($urandom_range(0, 24) == 0);
            ExReady = ($urandom_range(0, 3) != 0);
            if (!InstrValid || acc || ($urandom_range(0, 7) == 0)) begin
                InstrValid = ($urandom_range(0, 4) != 0);
                Instr      = rand_instr();
            end
            @(negedge clk);
            acc = InstrValid && rdy_h;
        end

        @(posedge clk);
        #1;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        reset = 1'b0;
        step();
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
